// File: rtl/spi_sched.sv
`timescale 1ns/1ps
// spi_sched: orders and formats transfers for the shared SPI shifter (preamp > ADC > DAC).
// Optional transfer watchdog: define SPI_SCHED_WDOG_EN.
module spi_sched #(
  parameter int ADC_DIV     = 4,
  parameter int WDOG_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] dac_a_in,
  input  logic [11:0] dac_b_in,
  input  logic [11:0] dac_c_in,
  input  logic [11:0] dac_d_in,
  input  logic [7:0]  amp_in,
  output logic        ena_out,
  output logic [13:0] adc_a_out,
  output logic [13:0] adc_b_out,
  output logic        adc_valid,
  output logic        wdog_err,
  output logic        xfer_start,
  output logic [1:0]  xfer_dest,
  output logic [5:0]  xfer_len,
  output logic [23:0] xfer_tx,
  input  logic        xfer_busy,
  input  logic        xfer_done,
  input  logic [33:0] xfer_rx
);
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_t;

  localparam logic [1:0] DEST_DAC   = 2'd0;
  localparam logic [1:0] DEST_AMP   = 2'd1;
  localparam logic [1:0] DEST_ADC   = 2'd2;
  localparam logic [7:0] FRAME_LAST = 8'(ADC_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  ch_q;
  logic [7:0]  frame_q;
  logic        amp_pend_q;
  logic        adc_pend_q;
  logic [7:0]  amp_shadow_q;
  logic [11:0] snap_q [4];
  logic [11:0] dac_live [4];
  logic [1:0]  dest_q;
  logic [5:0]  len_q;
  logic [23:0] tx_q;
  logic        ena_q;
  logic        adc_valid_q;
  logic [13:0] adc_a_q;
  logic [13:0] adc_b_q;
  logic        amp_req;
  logic        done_ok;
  logic        timeout;
  logic [1:0]  sel_dest;
  logic [5:0]  sel_len;
  logic [23:0] sel_tx;
  logic [11:0] dac_data;
  logic        unused_rx;

  assign dac_live[0] = dac_a_in;
  assign dac_live[1] = dac_b_in;
  assign dac_live[2] = dac_c_in;
  assign dac_live[3] = dac_d_in;
  assign unused_rx   = ^{xfer_rx[33:32], xfer_rx[17:16], xfer_rx[1:0]};

  assign amp_req = amp_pend_q | (amp_in != amp_shadow_q);
  assign done_ok = (state_q == S_WAIT) && xfer_done;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!xfer_busy) state_d = S_ARB;
      S_ARB:   state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (xfer_done)    state_d = S_ARB;
        else if (timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Channel 0 goes out live and is captured in the same edge, so the whole frame is coherent.
  always_comb begin
    dac_data = (ch_q == 2'd0) ? dac_a_in : snap_q[ch_q];
    sel_dest = DEST_DAC;
    sel_len  = 6'd24;
    sel_tx   = {((ch_q == 2'd3) ? 4'b0010 : 4'b0000), 2'b00, ch_q, dac_data, 4'h0};
    if (amp_req) begin
      sel_dest = DEST_AMP;
      sel_len  = 6'd8;
      sel_tx   = {amp_in, 16'h0000};
    end else if (adc_pend_q) begin
      sel_dest = DEST_ADC;
      sel_len  = 6'd34;
      sel_tx   = 24'h000000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
    end else if (state_q == S_ARB && sel_dest == DEST_DAC && ch_q == 2'd0) begin
      for (int i = 0; i < 4; i++) snap_q[i] <= dac_live[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q         <= '0;
      frame_q      <= '0;
      amp_pend_q   <= 1'b1;
      adc_pend_q   <= 1'b0;
      amp_shadow_q <= '0;
      dest_q       <= '0;
      len_q        <= '0;
      tx_q         <= '0;
      ena_q        <= 1'b0;
      adc_valid_q  <= 1'b0;
      adc_a_q      <= '0;
      adc_b_q      <= '0;
    end else begin
      ena_q       <= 1'b0;
      adc_valid_q <= 1'b0;
      if (state_q == S_ARB) begin
        dest_q <= sel_dest;
        len_q  <= sel_len;
        tx_q   <= sel_tx;
        if (sel_dest == DEST_AMP) begin
          amp_shadow_q <= amp_in;
          amp_pend_q   <= 1'b0;
        end else if (sel_dest == DEST_ADC) begin
          adc_pend_q <= 1'b0;
        end
      end
      if (done_ok) begin
        if (dest_q == DEST_DAC) begin
          ch_q <= ch_q + 2'd1;
          if (ch_q == 2'd3) begin
            ena_q <= 1'b1;
            if (frame_q == FRAME_LAST) begin
              frame_q    <= '0;
              adc_pend_q <= 1'b1;
            end else begin
              frame_q <= frame_q + 8'd1;
            end
          end
        end else if (dest_q == DEST_ADC) begin
          adc_a_q     <= xfer_rx[31:18];
          adc_b_q     <= xfer_rx[15:2];
          adc_valid_q <= 1'b1;
        end
      end
      // An abandoned AMP/ADC transfer must be re-requested; DAC retries because ch_q never advanced.
      if (timeout) begin
        if (dest_q == DEST_AMP) amp_pend_q <= 1'b1;
        if (dest_q == DEST_ADC) adc_pend_q <= 1'b1;
      end
    end
  end

`ifdef SPI_SCHED_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_cnt_q;
  logic        wdog_err_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != S_WAIT) wdog_cnt_q <= '0;
    else                            wdog_cnt_q <= wdog_cnt_q + 16'd1;
  end

  assign timeout = (state_q == S_WAIT) && !xfer_done && (wdog_cnt_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (reset)        wdog_err_q <= 1'b0;
    else if (timeout) wdog_err_q <= 1'b1;
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign timeout     = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  assign xfer_start = (state_q == S_ISSUE);
  assign xfer_dest  = dest_q;
  assign xfer_len   = len_q;
  assign xfer_tx    = tx_q;
  assign ena_out    = ena_q;
  assign adc_valid  = adc_valid_q;
  assign adc_a_out  = adc_a_q;
  assign adc_b_out  = adc_b_q;
endmodule
